dm_cmd_arbiter: RTL and testbench
=================================

DM_CMD_ARBITER -- requirements
Module: dm_cmd_arbiter

Interface
REQ-001 SHALL have parameter OST_DEPTH, default 4, max outstanding commands awaiting status (power of 2, 2..16).
REQ-002 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have s0_cmd_tvalid/s0_cmd_tready  in/out  1  requester 0 (weight) command handshake; s0_cmd_tdata  in  72  DataMover command.
REQ-004 SHALL have s1_cmd_tvalid/s1_cmd_tready/s1_cmd_tdata  in/out/in  1/1/72  requester 1 (activation) command.
REQ-005 SHALL have m_cmd_tvalid/m_cmd_tdata  out  1/72; m_cmd_tready  in  1  to DataMover MM2S command port.
REQ-006 SHALL have s_sts_tvalid/s_sts_tdata  in  1/8; s_sts_tready  out  1  DataMover status.
REQ-007 SHALL have mN_sts_tvalid/mN_sts_tdata  out  1/8; mN_sts_tready  in  1  routed status, N=0,1.
REQ-008 SHALL have ost_cnt  out  5  outstanding count; busy  out  1  (ost_cnt!=0 or m_cmd_tvalid); err_cnt  out  8  status error count.

Function
REQ-009 SHALL use FSM states ARB, ISSUE; ARB->ISSUE on a grant, ISSUE->ARB on m_cmd_tvalid&m_cmd_tready.
REQ-010 In ARB, SHALL grant only when ost_cnt<OST_DEPTH; single requester valid -> grant it; both valid -> grant the one not granted last (round-robin pointer, resets to favour requester 0).
REQ-011 On grant SHALL pulse sN_cmd_tready for exactly one cycle, latch sN_cmd_tdata, and assert m_cmd_tvalid the following cycle (1-cycle latency).
REQ-012 SHALL replace tag field bits [67:64] of the latched command with {2'b00, requester id, seq bit}; seq bit toggles per issue per requester; all other bits pass unchanged.
REQ-013 SHALL hold m_cmd_tvalid and m_cmd_tdata stable until m_cmd_tready; no sN_cmd_tready in ISSUE.
REQ-014 On m_cmd handshake SHALL push granted id and issued tag into an in-order FIFO and update round-robin pointer.
REQ-015 SHALL route status in issue order: FIFO non-empty -> mN_sts_tvalid=s_sts_tvalid for N=head id, other valid 0, s_sts_tready=mN_sts_tready; pop on s_sts handshake.
REQ-016 FIFO empty -> s_sts_tready=1, status discarded, both mN_sts_tvalid=0, err_cnt increments (saturating at 255).
REQ-017 Simultaneous push and pop SHALL leave ost_cnt unchanged; ost_cnt never exceeds OST_DEPTH nor wraps below 0.
REQ-018 mN_sts_tdata SHALL equal s_sts_tdata combinationally.

Reset
REQ-019 While rst_n=0 at a clk edge: state ARB, m_cmd_tvalid=0, m_cmd_tdata=0, sN_cmd_tready=0, FIFO empty, ost_cnt=0, err_cnt=0, seq bits 0, pointer favours requester 0.
REQ-020 Reset mid-ISSUE SHALL drop the latched command without issuing; status arriving after reset follows REQ-016.
REQ-021 Combinational outputs SHALL be 0 (s_sts_tready 1) during reset per REQ-016 empty behaviour.

Configuration
REQ-022 Macro DM_ARB_STS_CHECK_EN defined: on each popped status, compare s_sts_tdata[3:0] with FIFO head tag and check bits [6:4]==0 and bit7==1; any mismatch increments err_cnt (saturating).
REQ-023 Macro undefined: no tag/bit check; err_cnt counts only REQ-016 discards; routing unchanged.

Structure
REQ-024 Shared package dm_pkg SHALL hold cmd field positions (BTT [22:0], TYPE 23, DSA [29:24], EOF 30, DRR 31, ADDR [63:32], TAG [67:64], RSVD [71:68]), status bit positions, FSM state encoding.
REQ-025 In-order FIFO SHALL be sub-module dm_tag_fifo (width 5: id+tag, depth OST_DEPTH, full/empty/count outputs).

Verification
REQ-026 s0 only valid, cmd addr 0x1000_0000 btt 0x100, m_cmd_tready=1 -> s0_cmd_tready pulse 1 cycle, m_cmd_tvalid next cycle, tag 0x0, ost_cnt=1.
REQ-027 s0,s1 both valid continuously, 4 issues -> grant order 0,1,0,1; tags 0x0,0x2,0x1,0x3.
REQ-028 Issue 4 with no status -> ost_cnt=4, no further sN_cmd_tready; one status 0x80 -> pop, next grant allowed.
REQ-029 Status routing: issues 0 then 1, statuses 0x80,0x82 with m0_sts_tready=0 for 3 cycles -> s_sts_tready=0 those cycles, then m0 receives 0x80, m1 receives 0x82.
REQ-030 Status with empty FIFO -> accepted, no mN_sts_tvalid, err_cnt=1; with DM_ARB_STS_CHECK_EN, status 0xC0 for tag 0 -> err_cnt increments.
REQ-031 rst_n=0 during ISSUE with m_cmd_tready=0 -> next cycle m_cmd_tvalid=0, ost_cnt=0, busy=0.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the DataMover command arbiter: command/status field
// positions, FSM encoding and the in-order tracking entry.
package dm_pkg;

  localparam int unsigned CMD_W  = 72;
  localparam int unsigned STS_W  = 8;
  localparam int unsigned TAG_W  = 4;

  localparam int unsigned CMD_BTT_LSB  = 0;
  localparam int unsigned CMD_BTT_MSB  = 22;
  localparam int unsigned CMD_TYPE_BIT = 23;
  localparam int unsigned CMD_DSA_LSB  = 24;
  localparam int unsigned CMD_DSA_MSB  = 29;
  localparam int unsigned CMD_EOF_BIT  = 30;
  localparam int unsigned CMD_DRR_BIT  = 31;
  localparam int unsigned CMD_ADDR_LSB = 32;
  localparam int unsigned CMD_ADDR_MSB = 63;
  localparam int unsigned CMD_TAG_LSB  = 64;
  localparam int unsigned CMD_TAG_MSB  = 67;
  localparam int unsigned CMD_RSVD_LSB = 68;
  localparam int unsigned CMD_RSVD_MSB = 71;

  localparam int unsigned STS_TAG_LSB    = 0;
  localparam int unsigned STS_TAG_MSB    = 3;
  localparam int unsigned STS_INTERR_BIT = 4;
  localparam int unsigned STS_DECERR_BIT = 5;
  localparam int unsigned STS_SLVERR_BIT = 6;
  localparam int unsigned STS_OKAY_BIT   = 7;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_ISSUE = 1'b1
  } arb_state_e;

  // One outstanding command: who asked for it and the tag it went out with
  typedef struct packed {
    logic             id;
    logic [TAG_W-1:0] tag;
  } ost_entry_t;

  localparam int unsigned OST_ENTRY_W = $bits(ost_entry_t);

  function automatic logic [TAG_W-1:0] mk_tag(input logic id, input logic seq);
    return {2'b00, id, seq};
  endfunction

endpackage

// File: rtl/dm_tag_fifo.sv
// In-order FIFO of outstanding command entries; head is presented combinationally.
module dm_tag_fifo #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dm_cmd_arbiter.sv
// Round-robin arbiter of two requesters onto one DataMover MM2S command port,
// with in-order status routing. Optional status check: DM_ARB_STS_CHECK_EN.
module dm_cmd_arbiter
  import dm_pkg::*;
#(
  parameter int unsigned OST_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s0_cmd_tvalid,
  output logic             s0_cmd_tready,
  input  logic [CMD_W-1:0] s0_cmd_tdata,
  input  logic             s1_cmd_tvalid,
  output logic             s1_cmd_tready,
  input  logic [CMD_W-1:0] s1_cmd_tdata,
  output logic             m_cmd_tvalid,
  input  logic             m_cmd_tready,
  output logic [CMD_W-1:0] m_cmd_tdata,
  input  logic             s_sts_tvalid,
  output logic             s_sts_tready,
  input  logic [STS_W-1:0] s_sts_tdata,
  output logic             m0_sts_tvalid,
  input  logic             m0_sts_tready,
  output logic [STS_W-1:0] m0_sts_tdata,
  output logic             m1_sts_tvalid,
  input  logic             m1_sts_tready,
  output logic [STS_W-1:0] m1_sts_tdata,
  output logic [4:0]       ost_cnt,
  output logic             busy,
  output logic [7:0]       err_cnt
);

  localparam int unsigned CNT_W = $clog2(OST_DEPTH) + 1;

  arb_state_e       state;
  logic             gnt_id;
  logic             last_id;
  logic [1:0]       seq;
  logic             gnt_valid;
  logic             gnt_sel;
  logic [CMD_W-1:0] gnt_data;
  logic             cmd_hs;
  ost_entry_t       push_entry;
  ost_entry_t       head_entry;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_cnt;
  logic             sts_pop;
  logic             sts_drop;
  logic             sts_bad;

  // Grant selection: alternate when both request, else serve whoever asks
  always_comb begin
    gnt_sel = s1_cmd_tvalid;
    if (s0_cmd_tvalid && s1_cmd_tvalid) gnt_sel = ~last_id;
    gnt_valid = rst_n && (state == ST_ARB) && !fifo_full &&
                (s0_cmd_tvalid || s1_cmd_tvalid);
    gnt_data = gnt_sel ? s1_cmd_tdata : s0_cmd_tdata;
    gnt_data[CMD_TAG_MSB:CMD_TAG_LSB] = mk_tag(gnt_sel, seq[gnt_sel]);
  end

  assign s0_cmd_tready = gnt_valid && !gnt_sel;
  assign s1_cmd_tready = gnt_valid && gnt_sel;
  assign cmd_hs        = m_cmd_tvalid && m_cmd_tready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_ARB;
      m_cmd_tvalid <= 1'b0;
      m_cmd_tdata  <= '0;
      gnt_id       <= 1'b0;
      last_id      <= 1'b1;
      seq          <= 2'b00;
    end else begin
      case (state)
        ST_ARB: begin
          if (gnt_valid) begin
            state        <= ST_ISSUE;
            m_cmd_tvalid <= 1'b1;
            m_cmd_tdata  <= gnt_data;
            gnt_id       <= gnt_sel;
            seq[gnt_sel] <= ~seq[gnt_sel];
          end
        end
        ST_ISSUE: begin
          if (cmd_hs) begin
            state        <= ST_ARB;
            m_cmd_tvalid <= 1'b0;
            last_id      <= gnt_id;
          end
        end
        default: state <= ST_ARB;
      endcase
    end
  end

  assign push_entry.id  = gnt_id;
  assign push_entry.tag = m_cmd_tdata[CMD_TAG_MSB:CMD_TAG_LSB];

  dm_tag_fifo #(
    .WIDTH (OST_ENTRY_W),
    .DEPTH (OST_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cmd_hs),
    .push_data (push_entry),
    .pop       (sts_pop),
    .head      (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  // Status follows the oldest outstanding command; with none it is swallowed
  always_comb begin
    m0_sts_tvalid = 1'b0;
    m1_sts_tvalid = 1'b0;
    s_sts_tready  = 1'b1;
    if (rst_n && !fifo_empty) begin
      if (head_entry.id) begin
        m1_sts_tvalid = s_sts_tvalid;
        s_sts_tready  = m1_sts_tready;
      end else begin
        m0_sts_tvalid = s_sts_tvalid;
        s_sts_tready  = m0_sts_tready;
      end
    end
  end

  assign m0_sts_tdata = s_sts_tdata;
  assign m1_sts_tdata = s_sts_tdata;
  assign sts_pop      = rst_n && !fifo_empty && s_sts_tvalid && s_sts_tready;
  assign sts_drop     = rst_n && fifo_empty && s_sts_tvalid;

`ifdef DM_ARB_STS_CHECK_EN
  assign sts_bad = sts_pop &&
    ((s_sts_tdata[STS_TAG_MSB:STS_TAG_LSB] != head_entry.tag) ||
     (s_sts_tdata[STS_SLVERR_BIT:STS_INTERR_BIT] != 3'b000) ||
     !s_sts_tdata[STS_OKAY_BIT]);
`else
  logic unused_head_tag;
  assign unused_head_tag = ^head_entry.tag;
  assign sts_bad         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if ((sts_drop || sts_bad) && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  assign ost_cnt = 5'(fifo_cnt);
  assign busy    = (ost_cnt != 5'd0) || m_cmd_tvalid;

endmodule

// File: tb/tb_dm_cmd_arbiter.sv
// Bench for dm_cmd_arbiter: directed scenarios then random traffic, all checked
// cycle by cycle against a transaction-level reference model.
module tb_dm_cmd_arbiter;

  localparam int unsigned OST_DEPTH = 4;

  logic        clk, rst_n;
  logic        s0_cmd_tvalid, s0_cmd_tready, s1_cmd_tvalid, s1_cmd_tready;
  logic [71:0] s0_cmd_tdata, s1_cmd_tdata, m_cmd_tdata;
  logic        m_cmd_tvalid, m_cmd_tready;
  logic        s_sts_tvalid, s_sts_tready;
  logic [7:0]  s_sts_tdata, m0_sts_tdata, m1_sts_tdata;
  logic        m0_sts_tvalid, m0_sts_tready, m1_sts_tvalid, m1_sts_tready;
  logic [4:0]  ost_cnt;
  logic        busy;
  logic [7:0]  err_cnt;

  dm_cmd_arbiter #(.OST_DEPTH(OST_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_cmd_tvalid(s0_cmd_tvalid), .s0_cmd_tready(s0_cmd_tready), .s0_cmd_tdata(s0_cmd_tdata),
    .s1_cmd_tvalid(s1_cmd_tvalid), .s1_cmd_tready(s1_cmd_tready), .s1_cmd_tdata(s1_cmd_tdata),
    .m_cmd_tvalid(m_cmd_tvalid), .m_cmd_tready(m_cmd_tready), .m_cmd_tdata(m_cmd_tdata),
    .s_sts_tvalid(s_sts_tvalid), .s_sts_tready(s_sts_tready), .s_sts_tdata(s_sts_tdata),
    .m0_sts_tvalid(m0_sts_tvalid), .m0_sts_tready(m0_sts_tready), .m0_sts_tdata(m0_sts_tdata),
    .m1_sts_tvalid(m1_sts_tvalid), .m1_sts_tready(m1_sts_tready), .m1_sts_tdata(m1_sts_tdata),
    .ost_cnt(ost_cnt), .busy(busy), .err_cnt(err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one command in flight at most, a queue of {id, tag}
  bit          mdl_inflight;
  bit          mdl_id;
  bit          mdl_last;
  bit [1:0]    mdl_seq;
  logic [71:0] mdl_cmd;
  bit [4:0]    mdl_q[$];
  int          mdl_err;

  bit       hs0, hs1, hs_sts;
  bit [3:0] issued_tags[$];

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] rand72();
    return 72'({$urandom(), $urandom(), $urandom()});
  endfunction

  task automatic model_reset();
    mdl_inflight = 1'b0;
    mdl_id       = 1'b0;
    mdl_last     = 1'b1;
    mdl_seq      = 2'b00;
    mdl_cmd      = '0;
    mdl_q.delete();
    mdl_err      = 0;
  endtask

  function automatic void bump_err();
    if (mdl_err < 255) mdl_err++;
  endfunction

  // Entered just after a rising edge; samples at the falling edge, advances the
  // model by what the next rising edge should do, returns just after that edge.
  task automatic cycle();
    bit eg0, eg1, sel, e_sr, e_v0, e_v1, pop, drop, gid;
    bit [4:0] head;
    #4;
    eg0 = 1'b0; eg1 = 1'b0; e_sr = 1'b1; e_v0 = 1'b0; e_v1 = 1'b0;
    pop = 1'b0; drop = 1'b0; head = '0;
    if (rst_n && !mdl_inflight && mdl_q.size() < OST_DEPTH && (s0_cmd_tvalid || s1_cmd_tvalid)) begin
      sel = (s0_cmd_tvalid && s1_cmd_tvalid) ? !mdl_last : s1_cmd_tvalid;
      eg0 = !sel;
      eg1 = sel;
    end
    if (rst_n && mdl_q.size() > 0) begin
      head = mdl_q[0];
      if (head[4]) begin e_v1 = s_sts_tvalid; e_sr = m1_sts_tready; end
      else         begin e_v0 = s_sts_tvalid; e_sr = m0_sts_tready; end
      pop = s_sts_tvalid && e_sr;
    end else if (rst_n && s_sts_tvalid) begin
      drop = 1'b1;
    end
    check("s0_cmd_tready", 72'(s0_cmd_tready), 72'(eg0));
    check("s1_cmd_tready", 72'(s1_cmd_tready), 72'(eg1));
    check("m_cmd_tvalid", 72'(m_cmd_tvalid), 72'(mdl_inflight));
    if (mdl_inflight) check("m_cmd_tdata", m_cmd_tdata, mdl_cmd);
    check("ost_cnt", 72'(ost_cnt), 72'(mdl_q.size()));
    check("busy", 72'(busy), 72'((mdl_q.size() != 0) || mdl_inflight));
    check("err_cnt", 72'(err_cnt), 72'(mdl_err));
    check("s_sts_tready", 72'(s_sts_tready), 72'(e_sr));
    check("m0_sts_tvalid", 72'(m0_sts_tvalid), 72'(e_v0));
    check("m1_sts_tvalid", 72'(m1_sts_tvalid), 72'(e_v1));
    check("m0_sts_tdata", 72'(m0_sts_tdata), 72'(s_sts_tdata));
    check("m1_sts_tdata", 72'(m1_sts_tdata), 72'(s_sts_tdata));
    if (rst_n && m_cmd_tvalid === 1'b1 && m_cmd_tready) issued_tags.push_back(m_cmd_tdata[67:64]);

    if (!rst_n) begin
      model_reset();
    end else begin
      if (pop) begin
`ifdef DM_ARB_STS_CHECK_EN
        if (s_sts_tdata[3:0] != head[3:0] || s_sts_tdata[6:4] != 3'b000 || !s_sts_tdata[7]) bump_err();
`endif
        void'(mdl_q.pop_front());
      end
      if (drop) bump_err();
      if (mdl_inflight && m_cmd_tready) begin
        mdl_q.push_back({mdl_id, mdl_cmd[67:64]});
        mdl_inflight = 1'b0;
        mdl_last     = mdl_id;
      end else if (eg0 || eg1) begin
        gid           = eg1;
        mdl_cmd       = gid ? s1_cmd_tdata : s0_cmd_tdata;
        mdl_cmd[67:64] = {2'b00, gid, mdl_seq[gid]};
        mdl_seq[gid]  = ~mdl_seq[gid];
        mdl_id        = gid;
        mdl_inflight  = 1'b1;
      end
    end
    hs0    = eg0;
    hs1    = eg1;
    hs_sts = pop || drop;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    s0_cmd_tvalid = 1'b0; s1_cmd_tvalid = 1'b0; s_sts_tvalid = 1'b0;
    m_cmd_tready = 1'b0; m0_sts_tready = 1'b0; m1_sts_tready = 1'b0;
    repeat (n) cycle();
    rst_n = 1'b1;
    issued_tags.delete();
    check("rst_m_cmd_tdata", m_cmd_tdata, 72'h0);
  endtask

  logic [71:0] cmd, exp_cmd;
  bit   [3:0]  exp_tags[4];

  initial begin
    rst_n = 1'b0;
    s0_cmd_tvalid = 1'b0; s1_cmd_tvalid = 1'b0; s_sts_tvalid = 1'b0;
    s0_cmd_tdata = '0; s1_cmd_tdata = '0; s_sts_tdata = '0;
    m_cmd_tready = 1'b0; m0_sts_tready = 1'b0; m1_sts_tready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset(2);

    // Single requester: tag rewritten, 1-cycle latency, one outstanding
    cmd = '0;
    cmd[63:32] = 32'h1000_0000; cmd[22:0] = 23'h100; cmd[23] = 1'b1;
    cmd[67:64] = 4'hF; cmd[71:68] = 4'hA;
    s0_cmd_tvalid = 1'b1; s0_cmd_tdata = cmd; m_cmd_tready = 1'b1;
    cycle();
    exp_cmd = cmd; exp_cmd[67:64] = 4'h0;
    check("a_m_cmd_tvalid", 72'(m_cmd_tvalid), 72'(1));
    check("a_m_cmd_tdata", m_cmd_tdata, exp_cmd);
    s0_cmd_tdata = rand72();
    #1;
    check("a_no_tready_in_issue", 72'(s0_cmd_tready), 72'(0));
    s0_cmd_tvalid = 1'b0;
    cycle();
    check("a_ost_cnt", 72'(ost_cnt), 72'(1));
    do_reset(1);

    // Both requesting: alternating grants and per-requester sequence bits
    s0_cmd_tvalid = 1'b1; s0_cmd_tdata = rand72();
    s1_cmd_tvalid = 1'b1; s1_cmd_tdata = rand72();
    m_cmd_tready = 1'b1;
    for (int k = 0; k < 40 && issued_tags.size() < 4; k++) begin
      cycle();
      if (hs0) s0_cmd_tdata = rand72();
      if (hs1) s1_cmd_tdata = rand72();
    end
    exp_tags = '{4'h0, 4'h2, 4'h1, 4'h3};
    check("b_issue_count", 72'(issued_tags.size()), 72'(4));
    for (int k = 0; k < 4; k++)
      if (k < issued_tags.size()) check("b_tag_order", 72'(issued_tags[k]), 72'(exp_tags[k]));
    check("b_ost_full", 72'(ost_cnt), 72'(4));
    repeat (5) cycle();
    check("b_ost_held", 72'(ost_cnt), 72'(4));
    s_sts_tvalid = 1'b1; s_sts_tdata = 8'h80; m0_sts_tready = 1'b1;
    cycle();
    s_sts_tvalid = 1'b0;
    check("b_ost_after_pop", 72'(ost_cnt), 72'(3));
    cycle();
    check("b_regrant", 72'(m_cmd_tvalid), 72'(1));
    do_reset(1);

    // Status routing in issue order with back-pressure on requester 0
    m_cmd_tready = 1'b1;
    s0_cmd_tvalid = 1'b1; s0_cmd_tdata = rand72();
    for (int k = 0; k < 10 && issued_tags.size() < 1; k++) begin
      cycle();
      if (hs0) s0_cmd_tvalid = 1'b0;
    end
    s1_cmd_tvalid = 1'b1; s1_cmd_tdata = rand72();
    for (int k = 0; k < 10 && issued_tags.size() < 2; k++) begin
      cycle();
      if (hs1) s1_cmd_tvalid = 1'b0;
    end
    check("c_ost", 72'(ost_cnt), 72'(2));
    s_sts_tvalid = 1'b1; s_sts_tdata = 8'h80; m0_sts_tready = 1'b0; m1_sts_tready = 1'b1;
    repeat (3) begin
      #1;
      check("c_sts_stall", 72'(s_sts_tready), 72'(0));
      cycle();
    end
    m0_sts_tready = 1'b1;
    #1;
    check("c_m0_valid", 72'(m0_sts_tvalid), 72'(1));
    check("c_m0_data", 72'(m0_sts_tdata), 72'(8'h80));
    check("c_m1_idle", 72'(m1_sts_tvalid), 72'(0));
    cycle();
    s_sts_tdata = 8'h82;
    #1;
    check("c_m1_valid", 72'(m1_sts_tvalid), 72'(1));
    check("c_m1_data", 72'(m1_sts_tdata), 72'(8'h82));
    check("c_m0_idle", 72'(m0_sts_tvalid), 72'(0));
    cycle();
    s_sts_tvalid = 1'b0;
    check("c_ost_drained", 72'(ost_cnt), 72'(0));
    do_reset(1);

    // Unexpected status is swallowed and counted
    s_sts_tvalid = 1'b1; s_sts_tdata = 8'h55;
    #1;
    check("d_drop_ready", 72'(s_sts_tready), 72'(1));
    check("d_drop_m0", 72'(m0_sts_tvalid), 72'(0));
    cycle();
    s_sts_tvalid = 1'b0;
    check("d_err_cnt", 72'(err_cnt), 72'(1));
`ifdef DM_ARB_STS_CHECK_EN
    m_cmd_tready = 1'b1; m0_sts_tready = 1'b1;
    s0_cmd_tvalid = 1'b1; s0_cmd_tdata = rand72();
    for (int k = 0; k < 10 && issued_tags.size() < 1; k++) begin
      cycle();
      if (hs0) s0_cmd_tvalid = 1'b0;
    end
    s_sts_tvalid = 1'b1; s_sts_tdata = 8'hC0;
    cycle();
    s_sts_tvalid = 1'b0;
    check("d_bad_sts_err", 72'(err_cnt), 72'(2));
`endif
    s_sts_tvalid = 1'b1; s_sts_tdata = 8'h11;
    repeat (260) cycle();
    s_sts_tvalid = 1'b0;
    check("d_err_saturate", 72'(err_cnt), 72'(255));
    do_reset(1);

    // Reset while a command waits for m_cmd_tready
    s0_cmd_tvalid = 1'b1; s0_cmd_tdata = rand72(); m_cmd_tready = 1'b0;
    cycle();
    s0_cmd_tvalid = 1'b0;
    cycle();
    check("e_stalled", 72'(m_cmd_tvalid), 72'(1));
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    check("e_m_cmd_tvalid", 72'(m_cmd_tvalid), 72'(0));
    check("e_ost_cnt", 72'(ost_cnt), 72'(0));
    check("e_busy", 72'(busy), 72'(0));

    // Random traffic with handshakes held until accepted
    for (int i = 0; i < 3000; i++) begin
      if (!s0_cmd_tvalid || hs0) begin
        s0_cmd_tvalid = ($urandom_range(0, 2) != 0); s0_cmd_tdata = rand72();
      end
      if (!s1_cmd_tvalid || hs1) begin
        s1_cmd_tvalid = ($urandom_range(0, 2) != 0); s1_cmd_tdata = rand72();
      end
      if (!s_sts_tvalid || hs_sts) begin
        s_sts_tvalid = ($urandom_range(0, 2) == 0);
        if (mdl_q.size() > 0 && $urandom_range(0, 3) != 0) s_sts_tdata = 8'({4'h8, mdl_q[0][3:0]});
        else s_sts_tdata = 8'($urandom());
      end
      m_cmd_tready  = ($urandom_range(0, 3) != 0);
      m0_sts_tready = ($urandom_range(0, 2) != 0);
      m1_sts_tready = ($urandom_range(0, 2) != 0);
      rst_n         = ($urandom_range(0, 199) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
